execute_proc: RTL and testbench

EXECUTE_PROC -- requirements
Module: execute_proc

---
 rtl/execute_proc.sv | 216 +++++++++++++++++++++
 tb/tb_execute_proc.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/execute_proc.sv
// ---------------------------------------------------------------------------
// execute_proc
//
// Purpose:
//   Execute stage of a Y86-64 style pipeline. Produces the ALU result for the
//   memory/writeback stages, evaluates the branch/conditional-move condition
//   from the registered condition codes, maintains the condition codes
//   (zf, sf, of) and tracks processor status (AOK / HLT / INS).
//
// Ports:
//   clock    in   1   system clock, all state updates on the rising edge
//   reset    in   1   asynchronous active-high reset
//   in_code  in   4   instruction code from fetch
//   in_fun   in   4   function code from fetch
//   val_a    in  64   operand A from decode
//   val_b    in  64   operand B from decode
//   val_c    in  64   constant from fetch
//   val_e    out 64   ALU result (combinational)
//   cnd      out  1   condition outcome for cmovXX / jXX (combinational)
//   zf       out  1   registered zero flag
//   sf       out  1   registered sign flag
//   of       out  1   registered overflow flag
//   stat     out  2   01 AOK, 10 HLT, 11 INS
// ---------------------------------------------------------------------------
module execute_proc (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  in_code,
    input  logic [3:0]  in_fun,
    input  logic [63:0] val_a,
    input  logic [63:0] val_b,
    input  logic [63:0] val_c,
    output logic [63:0] val_e,
    output logic        cnd,
    output logic        zf,
    output logic        sf,
    output logic        of,
    output logic [1:0]  stat
);

    // Instruction codes
    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    // OPq function codes
    localparam logic [3:0] FUN_ADD = 4'h0;
    localparam logic [3:0] FUN_SUB = 4'h1;
    localparam logic [3:0] FUN_AND = 4'h2;
    localparam logic [3:0] FUN_XOR = 4'h3;

    // Stack pointer adjustment for call/ret/push/pop
    localparam logic [63:0] STACK_STEP = 64'd8;

    // Status encodings double as the stat output value
    typedef enum logic [1:0] {
        STAT_AOK = 2'b01,
        STAT_HLT = 2'b10,
        STAT_INS = 2'b11
    } statState_t;

    statState_t  state_q, state_d;
    logic        zf_q, zf_d;
    logic        sf_q, sf_d;
    logic        of_q, of_d;

    logic        isInvalid;
    logic        isAok;
    logic [63:0] aluResult;
    logic        aluOverflow;
    logic        ccLoad;
    logic        condTrue;

    assign isAok = (state_q == STAT_AOK);

    // Decode which instructions are illegal: unknown codes, OPq with an
    // undefined operation, or a condition selector beyond "g".
    always_comb begin
        isInvalid = 1'b0;
        if (in_code > ICODE_POPQ) begin
            isInvalid = 1'b1;
        end else if ((in_code == ICODE_OPQ) && (in_fun > FUN_XOR)) begin
            isInvalid = 1'b1;
        end else if (((in_code == ICODE_RRMOVQ) || (in_code == ICODE_JXX)) &&
                     (in_fun > 4'd6)) begin
            isInvalid = 1'b1;
        end
    end

    // OPq ALU. Subtraction is val_b - val_a so that the flags describe the
    // comparison "val_b versus val_a" used by the following branch.
    always_comb begin
        aluResult   = 64'd0;
        aluOverflow = 1'b0;
        case (in_fun)
            FUN_ADD: begin
                aluResult   = val_b + val_a;
                aluOverflow = (val_a[63] == val_b[63]) &&
                              (aluResult[63] != val_a[63]);
            end
            FUN_SUB: begin
                aluResult   = val_b - val_a;
                aluOverflow = (val_a[63] != val_b[63]) &&
                              (aluResult[63] != val_b[63]);
            end
            FUN_AND: aluResult = val_b & val_a;
            FUN_XOR: aluResult = val_b ^ val_a;
            default: begin
                aluResult   = 64'd0;
                aluOverflow = 1'b0;
            end
        endcase
    end

    // Result mux. Once halted or faulted, and for the faulting instruction
    // itself, the result is held at zero so nothing downstream acts on it.
    always_comb begin
        val_e = 64'd0;
        if (isAok && !isInvalid) begin
            case (in_code)
                ICODE_RRMOVQ: val_e = val_a;
                ICODE_IRMOVQ: val_e = val_c;
                ICODE_RMMOVQ,
                ICODE_MRMOVQ: val_e = val_b + val_c;
                ICODE_OPQ:    val_e = aluResult;
                ICODE_CALL,
                ICODE_PUSHQ:  val_e = val_b - STACK_STEP;
                ICODE_RET,
                ICODE_POPQ:   val_e = val_b + STACK_STEP;
                default:      val_e = 64'd0;
            endcase
        end
    end

    // Condition evaluation always uses the registered flags, so an OPq in
    // the same cycle cannot influence it; its flags appear one cycle later.
    always_comb begin
        condTrue = 1'b0;
        case (in_fun)
            4'd0:    condTrue = 1'b1;
            4'd1:    condTrue = (sf_q ^ of_q) | zf_q;
            4'd2:    condTrue = sf_q ^ of_q;
            4'd3:    condTrue = zf_q;
            4'd4:    condTrue = ~zf_q;
            4'd5:    condTrue = ~(sf_q ^ of_q);
            4'd6:    condTrue = ~(sf_q ^ of_q) & ~zf_q;
            default: condTrue = 1'b0;
        endcase
    end

    assign cnd = isAok &&
                 ((in_code == ICODE_RRMOVQ) || (in_code == ICODE_JXX)) &&
                 condTrue;

    // Flags load only for a well-formed OPq while running normally.
    assign ccLoad = isAok && (in_code == ICODE_OPQ) && (in_fun <= FUN_XOR);

    always_comb begin
        zf_d = zf_q;
        sf_d = sf_q;
        of_d = of_q;
        if (ccLoad) begin
            zf_d = (aluResult == 64'd0);
            sf_d = aluResult[63];
            of_d = aluOverflow;
        end
    end

    // Status next-state: halt and fault are terminal until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            STAT_AOK: begin
                if (in_code == ICODE_HALT) begin
                    state_d = STAT_HLT;
                end else if (isInvalid) begin
                    state_d = STAT_INS;
                end
            end
            STAT_HLT: state_d = STAT_HLT;
            STAT_INS: state_d = STAT_INS;
            default:  state_d = STAT_INS;
        endcase
    end

    // Status and condition-code registers. Reset leaves zf set so that an
    // "e" condition right after reset reads as equal.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= STAT_AOK;
            zf_q    <= 1'b1;
            sf_q    <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            zf_q    <= zf_d;
            sf_q    <= sf_d;
            of_q    <= of_d;
        end
    end

    assign zf   = zf_q;
    assign sf   = sf_q;
    assign of   = of_q;
    assign stat = state_q;

endmodule

// File: tb/tb_execute_proc.sv
// ---------------------------------------------------------------------------
// tb_execute_proc
//
// Directed vectors for execute_proc. Each stimulus cycle pushes its
// hand-computed expected outputs into a scoreboard queue; a monitor pops one
// entry at every falling clock edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_execute_proc;

    logic        clock;
    logic        reset;
    logic [3:0]  inCode;
    logic [3:0]  inFun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [63:0] valE;
    logic        cnd;
    logic        zf;
    logic        sf;
    logic        of;
    logic [1:0]  stat;

    typedef struct {
        string       name;
        logic [63:0] valE;
        logic        cnd;
        logic        zf;
        logic        sf;
        logic        of;
        logic [1:0]  stat;
    } expect_t;

    expect_t sbQueue[$];

    int assertCount = 0;
    int failCount   = 0;

    execute_proc dut (
        .clock   (clock),
        .reset   (reset),
        .in_code (inCode),
        .in_fun  (inFun),
        .val_a   (valA),
        .val_b   (valB),
        .val_c   (valC),
        .val_e   (valE),
        .cnd     (cnd),
        .zf      (zf),
        .sf      (sf),
        .of      (of),
        .stat    (stat)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Compare one field and account for it
    task automatic checkField(input string name, input string field,
                              input logic [63:0] actual,
                              input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s.%s actual=0x%0h expected=0x%0h",
                     name, field, actual, expected);
        end
    endtask

    task automatic checkOutput(input expect_t exp);
        checkField(exp.name, "val_e", valE, exp.valE);
        checkField(exp.name, "cnd",   {63'd0, cnd},  {63'd0, exp.cnd});
        checkField(exp.name, "zf",    {63'd0, zf},   {63'd0, exp.zf});
        checkField(exp.name, "sf",    {63'd0, sf},   {63'd0, exp.sf});
        checkField(exp.name, "of",    {63'd0, of},   {63'd0, exp.of});
        checkField(exp.name, "stat",  {62'd0, stat}, {62'd0, exp.stat});
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    initial begin
        expect_t exp;
        forever begin
            @(negedge clock);
            if (sbQueue.size() > 0) begin
                exp = sbQueue.pop_front();
                checkOutput(exp);
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge and record what
    // the outputs must be during that cycle.
    task automatic applyStimulus(input string name, input logic rst,
                                 input logic [3:0] code, input logic [3:0] fun,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] c,
                                 input logic [63:0] expValE, input logic expCnd,
                                 input logic expZf, input logic expSf,
                                 input logic expOf, input logic [1:0] expStat);
        expect_t exp;
        @(posedge clock);
        #1;
        reset  = rst;
        inCode = code;
        inFun  = fun;
        valA   = a;
        valB   = b;
        valC   = c;
        exp.name = name;
        exp.valE = expValE;
        exp.cnd  = expCnd;
        exp.zf   = expZf;
        exp.sf   = expSf;
        exp.of   = expOf;
        exp.stat = expStat;
        sbQueue.push_back(exp);
    endtask

    localparam logic [63:0] MAXPOS = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ALLONE = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        reset  = 1'b1;
        inCode = 4'h1;
        inFun  = 4'h0;
        valA   = 64'd0;
        valB   = 64'd0;
        valC   = 64'd0;

        //            name          rst code  fun  valA    valB    valC        valE                   cnd zf sf of stat
        applyStimulus("rstIdle",    1, 4'h1, 4'h0, 64'd0,  64'd0,  64'd0,      64'd0,                 0, 1, 0, 0, 2'b01);
        applyStimulus("idle",       0, 4'h1, 4'h0, 64'd0,  64'd0,  64'd0,      64'd0,                 0, 1, 0, 0, 2'b01);
        applyStimulus("addOvf",     0, 4'h6, 4'h0, MAXPOS, MAXPOS, 64'd0,      64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0, 0, 2'b01);
        applyStimulus("addOvfCc",   0, 4'h1, 4'h0, 64'd0,  64'd0,  64'd0,      64'd0,                 0, 0, 1, 1, 2'b01);
        applyStimulus("subZero",    0, 4'h6, 4'h1, 64'd5,  64'd5,  64'd0,      64'd0,                 0, 0, 1, 1, 2'b01);
        applyStimulus("jeTaken",    0, 4'h7, 4'h3, 64'd0,  64'd0,  64'd0,      64'd0,                 1, 1, 0, 0, 2'b01);
        applyStimulus("jneNot",     0, 4'h7, 4'h4, 64'd0,  64'd0,  64'd0,      64'd0,                 0, 1, 0, 0, 2'b01);
        applyStimulus("jleTaken",   0, 4'h7, 4'h1, 64'd0,  64'd0,  64'd0,      64'd0,                 1, 1, 0, 0, 2'b01);
        // OPq with nonzero result: flags still show zf=1 in its own cycle
        applyStimulus("opSameCyc",  0, 4'h6, 4'h0, 64'd1,  64'd2,  64'd0,      64'd3,                 0, 1, 0, 0, 2'b01);
        applyStimulus("jeAfterOp",  0, 4'h7, 4'h3, 64'd0,  64'd0,  64'd0,      64'd0,                 0, 0, 0, 0, 2'b01);
        applyStimulus("rrmovq",     0, 4'h2, 4'h0, 64'h55, 64'd0,  64'd0,      64'h55,                1, 0, 0, 0, 2'b01);
        applyStimulus("cmovge",     0, 4'h2, 4'h5, 64'h66, 64'd0,  64'd0,      64'h66,                1, 0, 0, 0, 2'b01);
        applyStimulus("jlNot",      0, 4'h7, 4'h2, 64'd0,  64'd0,  64'd0,      64'd0,                 0, 0, 0, 0, 2'b01);
        applyStimulus("pushq",      0, 4'hA, 4'h0, 64'd0,  64'h100, 64'd0,     64'hF8,                0, 0, 0, 0, 2'b01);
        applyStimulus("popq",       0, 4'hB, 4'h0, 64'd0,  64'h100, 64'd0,     64'h108,               0, 0, 0, 0, 2'b01);
        applyStimulus("rmmovq",     0, 4'h4, 4'h0, 64'd0,  64'h10, 64'h8,      64'h18,                0, 0, 0, 0, 2'b01);
        applyStimulus("mrmovqNeg",  0, 4'h5, 4'h0, 64'd0,  64'h20, 64'hFFFF_FFFF_FFFF_FFF8, 64'h18,   0, 0, 0, 0, 2'b01);
        applyStimulus("irmovq",     0, 4'h3, 4'h0, 64'd0,  64'd0,  64'h1234,   64'h1234,              0, 0, 0, 0, 2'b01);
        applyStimulus("call",       0, 4'h8, 4'h0, 64'd0,  64'h200, 64'd0,     64'h1F8,               0, 0, 0, 0, 2'b01);
        applyStimulus("ret",        0, 4'h9, 4'h0, 64'd0,  64'h200, 64'd0,     64'h208,               0, 0, 0, 0, 2'b01);
        applyStimulus("andq",       0, 4'h6, 4'h2, 64'hF0, 64'h3C, 64'd0,      64'h30,                0, 0, 0, 0, 2'b01);
        applyStimulus("subNeg",     0, 4'h6, 4'h1, 64'd1,  64'd0,  64'd0,      ALLONE,                0, 0, 0, 0, 2'b01);
        applyStimulus("jlTaken",    0, 4'h7, 4'h2, 64'd0,  64'd0,  64'd0,      64'd0,                 1, 0, 1, 0, 2'b01);
        applyStimulus("xorq",       0, 4'h6, 4'h3, 64'hF0, 64'h3C, 64'd0,      64'hCC,                0, 0, 1, 0, 2'b01);
        // Halt and its stickiness
        applyStimulus("halt",       0, 4'h0, 4'h0, 64'd0,  64'd0,  64'd0,      64'd0,                 0, 0, 0, 0, 2'b01);
        applyStimulus("hltOpq",     0, 4'h6, 4'h1, 64'd5,  64'd5,  64'd0,      64'd0,                 0, 0, 0, 0, 2'b10);
        applyStimulus("hltJmp",     0, 4'h7, 4'h0, 64'd0,  64'd0,  64'd0,      64'd0,                 0, 0, 0, 0, 2'b10);
        applyStimulus("hltRst",     1, 4'h1, 4'h0, 64'd0,  64'd0,  64'd0,      64'd0,                 0, 1, 0, 0, 2'b01);
        // Invalid instruction code and its stickiness
        applyStimulus("badCode",    0, 4'hC, 4'h0, 64'd0,  64'd0,  64'd0,      64'd0,                 0, 1, 0, 0, 2'b01);
        applyStimulus("insIrmov",   0, 4'h3, 4'h0, 64'd0,  64'd0,  64'h77,     64'd0,                 0, 1, 0, 0, 2'b11);
        applyStimulus("insRst",     1, 4'h3, 4'h0, 64'd0,  64'd0,  64'h77,     64'h77,                0, 1, 0, 0, 2'b01);
        applyStimulus("badCond",    0, 4'h7, 4'h7, 64'd0,  64'd0,  64'd0,      64'd0,                 0, 1, 0, 0, 2'b01);
        applyStimulus("insCond",    0, 4'h1, 4'h0, 64'd0,  64'd0,  64'd0,      64'd0,                 0, 1, 0, 0, 2'b11);
        applyStimulus("rstAgain",   1, 4'h1, 4'h0, 64'd0,  64'd0,  64'd0,      64'd0,                 0, 1, 0, 0, 2'b01);
        applyStimulus("badOpFun",   0, 4'h6, 4'h4, 64'd1,  64'd1,  64'd0,      64'd0,                 0, 1, 0, 0, 2'b01);
        applyStimulus("insOpFun",   0, 4'h6, 4'h0, 64'd1,  64'd1,  64'd0,      64'd0,                 0, 1, 0, 0, 2'b11);

        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 20 && sbQueue.size() > 0; i++) begin
            @(negedge clock);
        end
        #1;
        if (sbQueue.size() > 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL drain pending=%0d required=0", sbQueue.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
